// File: rtl/upsample_if.sv
// Buffer-side bus of the upsample controller: BUF2 read strobes, BUF1 write strobes and crossbar route.
// With UPSAMPLE_ZERO_INSERT_EN defined the bus also carries dst_w_zero.
interface upsample_if #(
   parameter int N_PE   = 8,
   parameter int ADDR_W = 16
);
   logic [N_PE-1:0]   src_r_en;
   logic [ADDR_W-1:0] src_r_addr;
   logic [N_PE-1:0]   dst_w_en;
   logic [ADDR_W-1:0] dst_w_addr;
   logic [1:0]        aybz_azby;
`ifdef UPSAMPLE_ZERO_INSERT_EN
   logic              dst_w_zero;
`endif

   modport master (
      output src_r_en, src_r_addr, dst_w_en, dst_w_addr, aybz_azby
`ifdef UPSAMPLE_ZERO_INSERT_EN
      , output dst_w_zero
`endif
   );

   modport slave (
      input src_r_en, src_r_addr, dst_w_en, dst_w_addr, aybz_azby
`ifdef UPSAMPLE_ZERO_INSERT_EN
      , input dst_w_zero
`endif
   );
endinterface

// File: rtl/upsample.sv
// Nearest-neighbour upsample controller: BUF2 reads -> BUF1 writes, one output pixel per cycle.
// Optional zero-insert mode is enabled by defining UPSAMPLE_ZERO_INSERT_EN.
module upsample #(
   parameter int N_PE   = 8,
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIM_W-1:0] cfg_data_ch,
   input  logic [DIM_W-1:0] cfg_data_wid,
   input  logic [DIM_W-1:0] cfg_data_hei,
   input  logic [3:0]       cfg_up_horiz,
   input  logic [3:0]       cfg_up_vert,
`ifdef UPSAMPLE_ZERO_INSERT_EN
   input  logic             cfg_zero_ins,
`endif
   output logic [DIM_W-1:0] cfg_out_wid,
   output logic [DIM_W-1:0] cfg_out_hei,
   output logic             done,
   upsample_if.master       bus
);
   localparam int LOG_N_PE = $clog2(N_PE);
   localparam int PW       = 2 * DIM_W;

   typedef enum logic [1:0] {IDLE, S_CB, S_CB_I} state_t;
   state_t state, state_nxt;

   logic [DIM_W-1:0]    cb, ox, ix, iy;
   logic [3:0]          hc, vc;
   logic [PW-1:0]       k;
   logic [3:0]          uhe, uve;
   logic [PW-1:0]       is_sz, os_sz;
   logic [DIM_W-1:0]    cbe;
   logic [LOG_N_PE-1:0] rem;
   logic                last_blk, rd_more, pix_vld, rd_fire, anchor;
   logic                blk_adv, job_end;
   logic [N_PE-1:0]     lane_mask;
   logic [ADDR_W-1:0]   src_addr, dst_addr;

   assign uhe         = (cfg_up_horiz == 4'd0) ? 4'd1 : cfg_up_horiz;
   assign uve         = (cfg_up_vert  == 4'd0) ? 4'd1 : cfg_up_vert;
   assign cfg_out_wid = cfg_data_wid * DIM_W'(uhe);
   assign cfg_out_hei = cfg_data_hei * DIM_W'(uve);
   assign is_sz       = PW'(cfg_data_wid) * PW'(cfg_data_hei);
   assign os_sz       = PW'(cfg_out_wid) * PW'(cfg_out_hei);

   // A partial trailing block of channels gets its own pass with a narrowed lane mask.
   assign rem       = cfg_data_ch[LOG_N_PE-1:0];
   assign cbe       = (cfg_data_ch >> LOG_N_PE) + DIM_W'(rem != '0);
   assign last_blk  = (cb + DIM_W'(1)) == cbe;
   assign lane_mask = (last_blk && rem != '0) ?
                      ((N_PE'(1) << rem) - N_PE'(1)) : '1;

   assign rd_more = (state == S_CB_I) && (k < os_sz);
   assign pix_vld = rd_more;
   assign anchor  = (hc == 4'd0) && (vc == 4'd0);
`ifdef UPSAMPLE_ZERO_INSERT_EN
   assign rd_fire = pix_vld && (!cfg_zero_ins || anchor);
`else
   assign rd_fire = pix_vld;
`endif

   assign src_addr = ADDR_W'(is_sz * PW'(cb) + PW'(iy) * PW'(cfg_data_wid) + PW'(ix));
   assign dst_addr = ADDR_W'(os_sz * PW'(cb) + k);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      blk_adv        = 1'b0;
      job_end        = 1'b0;
      bus.src_r_en   = '0;
      bus.src_r_addr = '0;
      case (state)
         IDLE:   if (start) state_nxt = S_CB;
         S_CB: begin
            if (last_blk) begin
               job_end   = 1'b1;
               state_nxt = IDLE;
            end else begin
               blk_adv   = 1'b1;
               state_nxt = S_CB_I;
            end
         end
         // Extra cycle after the last read lets the write stage drain.
         S_CB_I: if (!rd_more) state_nxt = S_CB;
         default: state_nxt = IDLE;
      endcase
      if (rd_fire) begin
         bus.src_r_en   = lane_mask;
         bus.src_r_addr = src_addr;
      end
   end

   assign bus.aybz_azby = 2'b10;

   // Source index walk: ix/iy advance only when the replication counters wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cb   <= '1;
         k    <= '0;
         ox   <= '0;
         ix   <= '0;
         iy   <= '0;
         hc   <= '0;
         vc   <= '0;
         done <= 1'b0;
      end else begin
         done <= job_end;
         if (job_end) cb <= '1;
         if (blk_adv) begin
            cb <= cb + DIM_W'(1);
            k  <= '0;
            ox <= '0;
            ix <= '0;
            iy <= '0;
            hc <= '0;
            vc <= '0;
         end else if (pix_vld) begin
            k <= k + PW'(1);
            if (ox == cfg_out_wid - DIM_W'(1)) begin
               ox <= '0;
               ix <= '0;
               hc <= '0;
               if (vc == uve - 4'd1) begin
                  vc <= '0;
                  iy <= iy + DIM_W'(1);
               end else begin
                  vc <= vc + 4'd1;
               end
            end else begin
               ox <= ox + DIM_W'(1);
               if (hc == uhe - 4'd1) begin
                  hc <= '0;
                  ix <= ix + DIM_W'(1);
               end else begin
                  hc <= hc + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.dst_w_en   <= '0;
         bus.dst_w_addr <= '0;
`ifdef UPSAMPLE_ZERO_INSERT_EN
         bus.dst_w_zero <= 1'b0;
`endif
      end else begin
         bus.dst_w_en   <= pix_vld ? lane_mask : '0;
         bus.dst_w_addr <= pix_vld ? dst_addr : '0;
`ifdef UPSAMPLE_ZERO_INSERT_EN
         bus.dst_w_zero <= pix_vld && cfg_zero_ins && !anchor;
`endif
      end
   end
endmodule

// File: tb/tb_upsample.sv
// Randomized + directed bench for upsample against a pixel-loop reference model.
// Zero-insert jobs are exercised when UPSAMPLE_ZERO_INSERT_EN is defined.
module tb_upsample;
   localparam int N_PE = 8;
   localparam int AW   = 16;
   localparam int DW   = 16;
   localparam int MAXL = 1024;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] cfg_data_ch = '0, cfg_data_wid = '0, cfg_data_hei = '0;
   logic [3:0]    cfg_up_horiz = '0, cfg_up_vert = '0;
   logic [DW-1:0] cfg_out_wid, cfg_out_hei;
   logic          done;
`ifdef UPSAMPLE_ZERO_INSERT_EN
   logic          cfg_zero_ins = 1'b0;
`endif

   upsample_if #(.N_PE(N_PE), .ADDR_W(AW)) bus ();

   upsample #(.N_PE(N_PE), .ADDR_W(AW), .DIM_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_data_ch(cfg_data_ch), .cfg_data_wid(cfg_data_wid), .cfg_data_hei(cfg_data_hei),
      .cfg_up_horiz(cfg_up_horiz), .cfg_up_vert(cfg_up_vert),
`ifdef UPSAMPLE_ZERO_INSERT_EN
      .cfg_zero_ins(cfg_zero_ins),
`endif
      .cfg_out_wid(cfg_out_wid), .cfg_out_hei(cfg_out_hei), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Expected per-cycle trace, cycle 0 = cycle in which start is sampled.
   int e_ren[MAXL], e_raddr[MAXL], e_wen[MAXL], e_waddr[MAXL], e_wz[MAXL], e_done[MAXL];
   int e_len, e_ow, e_oh;

   task automatic build(input int c_, w_, h_, uh_, uv_, zi_);
      int uhe, uve, os, is, cbe, base, n, m, k, cyc;
      bit rd;
      uhe = (uh_ == 0) ? 1 : uh_;
      uve = (uv_ == 0) ? 1 : uv_;
      e_ow = (w_ * uhe) & 16'hFFFF;
      e_oh = (h_ * uve) & 16'hFFFF;
      os = e_ow * e_oh;
      is = w_ * h_;
      cbe = (c_ + N_PE - 1) / N_PE;
      e_len = 4 + cbe * (os + 2);
      for (int i = 0; i < MAXL; i++) begin
         e_ren[i] = 0; e_raddr[i] = 0; e_wen[i] = 0; e_waddr[i] = 0; e_wz[i] = 0; e_done[i] = 0;
      end
      for (int b = 0; b < cbe; b++) begin
         base = 1 + b * (os + 2);
         n = c_ - b * N_PE;
         if (n > N_PE) n = N_PE;
         m = (1 << n) - 1;
         k = 0;
         for (int oy = 0; oy < e_oh; oy++)
            for (int ox = 0; ox < e_ow; ox++) begin
               cyc = base + 1 + k;
               rd = (zi_ == 0) || ((ox % uhe == 0) && (oy % uve == 0));
               if (rd) begin
                  e_ren[cyc]   = m;
                  e_raddr[cyc] = (is * b + (oy / uve) * w_ + ox / uhe) & 16'hFFFF;
               end
               e_wen[cyc + 1]   = m;
               e_waddr[cyc + 1] = (os * b + k) & 16'hFFFF;
               e_wz[cyc + 1]    = rd ? 0 : 1;
               k++;
            end
      end
      e_done[2 + cbe * (os + 2)] = 1;
   endtask

   task automatic run_job(input string nm, input int c_, w_, h_, uh_, uv_, zi_,
                          input int abort_at, input int inj_at);
      build(c_, w_, h_, uh_, uv_, zi_);
      cfg_data_ch = DW'(c_); cfg_data_wid = DW'(w_); cfg_data_hei = DW'(h_);
      cfg_up_horiz = 4'(uh_); cfg_up_vert = 4'(uv_);
`ifdef UPSAMPLE_ZERO_INSERT_EN
      cfg_zero_ins = zi_[0];
`endif
      for (int c = 0; c < e_len; c++) begin
         @(negedge clk);
         start = (c == 0) || (c == inj_at);
         if (c == abort_at) begin
            rst = 1'b0;
            #1;
            chk({nm, ":abort_ren"}, 64'(bus.src_r_en), 64'd0);
            chk({nm, ":abort_wen"}, 64'(bus.dst_w_en), 64'd0);
            start = 1'b0;
            repeat (2) begin
               @(negedge clk);
               chk({nm, ":rst_done"}, 64'(done), 64'd0);
               chk({nm, ":rst_ren"}, 64'(bus.src_r_en), 64'd0);
            end
            rst = 1'b1;
            return;
         end
         chk($sformatf("%s:ren@%0d", nm, c), 64'(bus.src_r_en), 64'(e_ren[c]));
         chk($sformatf("%s:wen@%0d", nm, c), 64'(bus.dst_w_en), 64'(e_wen[c]));
         chk($sformatf("%s:done@%0d", nm, c), 64'(done), 64'(e_done[c]));
         if (e_ren[c] != 0)
            chk($sformatf("%s:raddr@%0d", nm, c), 64'(bus.src_r_addr), 64'(e_raddr[c]));
         if (e_wen[c] != 0)
            chk($sformatf("%s:waddr@%0d", nm, c), 64'(bus.dst_w_addr), 64'(e_waddr[c]));
`ifdef UPSAMPLE_ZERO_INSERT_EN
         if (e_wen[c] != 0)
            chk($sformatf("%s:wz@%0d", nm, c), 64'(bus.dst_w_zero), 64'(e_wz[c]));
`endif
         if (c == 2)
            chk({nm, ":route"}, 64'(bus.aybz_azby), 64'd2);
      end
      start = 1'b0;
      chk({nm, ":ow"}, 64'(cfg_out_wid), 64'(e_ow));
      chk({nm, ":oh"}, 64'(cfg_out_hei), 64'(e_oh));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ren", 64'(bus.src_r_en), 64'd0);
      chk("rst_wen", 64'(bus.dst_w_en), 64'd0);
      chk("rst_raddr", 64'(bus.src_r_addr), 64'd0);
      chk("rst_waddr", 64'(bus.dst_w_addr), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      run_job("job1", 8, 2, 2, 2, 2, 0, -1, -1);
      run_job("job2", 11, 2, 1, 2, 1, 0, -1, -1);
      run_job("job3", 8, 3, 1, 0, 1, 0, -1, -1);
      run_job("job4a", 8, 2, 2, 2, 2, 0, 4, -1);
      run_job("job4b", 8, 2, 2, 2, 2, 0, -1, -1);
      run_job("job5a", 8, 2, 2, 2, 2, 0, -1, 5);
      run_job("job5b", 0, 2, 2, 2, 2, 0, -1, -1);
`ifdef UPSAMPLE_ZERO_INSERT_EN
      run_job("job6", 8, 2, 2, 2, 2, 1, -1, -1);
`endif
      for (int j = 0; j < 10; j++) begin
         int zi;
         zi = 0;
`ifdef UPSAMPLE_ZERO_INSERT_EN
         zi = int'($urandom_range(0, 1));
`endif
         run_job($sformatf("rnd%0d", j), int'($urandom_range(0, 20)), int'($urandom_range(1, 4)),
                 int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 zi, -1, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
